// File: rtl/accum_pkg.sv
// Shared types and default widths for the arithmetic-series accumulator engine.
package accum_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned SUM_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } accum_state_t;

endpackage

// File: rtl/accum_datapath.sv
// Term/accumulator datapath: latches limit/step, advances the series one term per strobe.
// Build option ACCUM_SATURATE_EN clamps the accumulator on carry-out instead of wrapping.
module accum_datapath
  import accum_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [W-1:0]     limit_i,
  input  logic [W-1:0]     step_i,
  output logic             can_adv_o,
  output logic [SUM_W-1:0] acc_o,
  output logic [W-1:0]     cnt_o,
  output logic             run_ovf_o
);

  logic [W-1:0]     limit_q, limit_d;
  logic [W-1:0]     step_q, step_d;
  logic [W-1:0]     term_q, term_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [W:0]       nxt_s;
  logic [SUM_W:0]   sum_s;
  logic [SUM_W-1:0] acc_add_s;
  logic             take_s;

  // Next-term adder, limit compare and accumulator adder with optional clamp.
  always_comb begin
    nxt_s  = {1'b0, term_q} + {1'b0, step_q};
    take_s = (nxt_s <= {1'b0, limit_q}) && !nxt_s[W] && (step_q != {W{1'b0}});
    sum_s  = {1'b0, acc_q} + {{(SUM_W + 1 - W){1'b0}}, nxt_s[W-1:0]};
`ifdef ACCUM_SATURATE_EN
    // Once clamped, every further add carries again, so the clamp holds for the run.
    if (sum_s[SUM_W]) begin
      acc_add_s = {SUM_W{1'b1}};
    end else begin
      acc_add_s = sum_s[SUM_W-1:0];
    end
`else
    acc_add_s = sum_s[SUM_W-1:0];
`endif
  end

  // Register next-state: load clears the run, advance accepts one term.
  always_comb begin
    limit_d = limit_q;
    step_d  = step_q;
    term_d  = term_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (load_i) begin
      limit_d = limit_i;
      step_d  = step_i;
      term_d  = {W{1'b0}};
      acc_d   = {SUM_W{1'b0}};
      cnt_d   = {W{1'b0}};
      ovf_d   = 1'b0;
    end else if (adv_i && take_s) begin
      term_d  = nxt_s[W-1:0];
      acc_d   = acc_add_s;
      cnt_d   = cnt_q + {{(W - 1){1'b0}}, 1'b1};
      ovf_d   = ovf_q | sum_s[SUM_W];
    end else begin
      term_d  = term_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit_q <= {W{1'b0}};
      step_q  <= {W{1'b0}};
      term_q  <= {W{1'b0}};
      acc_q   <= {SUM_W{1'b0}};
      cnt_q   <= {W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      limit_q <= limit_d;
      step_q  <= step_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign can_adv_o = take_s;
  assign acc_o     = acc_q;
  assign cnt_o     = cnt_q;
  assign run_ovf_o = ovf_q;

endmodule

// File: rtl/accum_seq_engine.sv
// Arithmetic-series accumulator with start/busy/done handshake and registered results.
// Optional build macro: ACCUM_SATURATE_EN (clamp instead of wrap on accumulator overflow).
module accum_seq_engine
  import accum_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [W-1:0]     limit_i,
  input  logic [W-1:0]     step_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SUM_W-1:0] result_o,
  output logic [W-1:0]     count_o,
  output logic             ovf_o
);

  accum_state_t     state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SUM_W-1:0] result_q, result_d;
  logic [W-1:0]     count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             load_s;
  logic             adv_s;
  logic             can_adv_s;
  logic [SUM_W-1:0] acc_s;
  logic [W-1:0]     cnt_s;
  logic             run_ovf_s;

  accum_datapath #(
    .W     (W),
    .SUM_W (SUM_W)
  ) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load_s),
    .adv_i     (adv_s),
    .limit_i   (limit_i),
    .step_i    (step_i),
    .can_adv_o (can_adv_s),
    .acc_o     (acc_s),
    .cnt_o     (cnt_s),
    .run_ovf_o (run_ovf_s)
  );

  // Control FSM next-state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    load_s   = 1'b0;
    adv_s    = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_s  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (can_adv_s) begin
          adv_s   = 1'b1;
          state_d = ST_RUN;
        end else begin
          result_d = acc_s;
          count_d  = cnt_s;
          ovf_d    = run_ovf_s;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {SUM_W{1'b0}};
      count_q  <= {W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign count_o  = count_q;
  assign ovf_o    = ovf_q;

endmodule
